// File: rtl/vram_pkg.sv
// Shared types and sizing for the VRAM strip write arbiter.
package vram_pkg;

  localparam int unsigned VRAM_AW     = 19;
  localparam int unsigned VRAM_DW     = 12;
  localparam int unsigned STRIP_LINES = 32;
  localparam int unsigned STRIP_COLS  = 640;
  localparam int unsigned STRIP_WORDS = STRIP_LINES * STRIP_COLS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } arb_state_t;

  // Round-robin successor of a requester index.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Requester-side write bus: packed per-requester request/address/data and one-hot grant.
interface vram_write_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 19,
  parameter int unsigned DW   = 12
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] waddr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;

  modport master (
    output req,
    output waddr,
    output wdata,
    input  gnt
  );

  modport slave (
    input  req,
    input  waddr,
    input  wdata,
    output gnt
  );

endinterface

// File: rtl/vram_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            any
);

  logic [PW:0]   pos;
  logic [PW-1:0] idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    pos    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) begin
        pos = pos - (PW+1)'(NREQ);
      end
      idx = pos[PW-1:0];
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        winner   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the VRAM strip write port with ping-pong bank select.
// Define VRAM_ARB_PRIO_EN to make requester 0 strict priority over the rotation.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned AW          = VRAM_AW,
  parameter int unsigned DW          = VRAM_DW,
  parameter int unsigned STRIP_WORDS = vram_pkg::STRIP_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  window_open,
  input  logic                  swap,
  vram_write_arbiter_if.slave   wr,
  output logic                  vram_we,
  output logic [AW-1:0]         vram_addr,
  output logic [DW-1:0]         vram_din,
  output logic                  bank_sel,
  output logic [7:0]            err_cnt,
  output logic                  busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;

  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic [NREQ-1:0] gnt_c;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            win_in_range;

`ifdef VRAM_ARB_PRIO_EN
  // Requester 0 is served by the priority path, never by the rotation.
  assign pick_req = wr.req & ~NREQ'(1);
`else
  assign pick_req = wr.req;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req    (pick_req),
    .ptr    (ptr),
    .gnt    (pick_gnt),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // State and round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state, grant and pointer update.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_c     = '0;
    win_idx   = '0;
    win_any   = 1'b0;
    case (state)
      IDLE: begin
        if (window_open) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!window_open) begin
          state_nxt = IDLE;
        end else begin
`ifdef VRAM_ARB_PRIO_EN
          if (wr.req[0]) begin
            gnt_c   = NREQ'(1);
            win_idx = '0;
            win_any = 1'b1;
          end else
`endif
          if (pick_any) begin
            gnt_c   = pick_gnt;
            win_idx = pick_idx;
            win_any = 1'b1;
            ptr_nxt = PW'(next_idx(32'(pick_idx), NREQ));
          end
        end
      end
      SWAP: begin
        ptr_nxt   = '0;
        state_nxt = window_open ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A strip boundary pre-empts any grant in the same cycle.
    if (swap) begin
      state_nxt = SWAP;
      gnt_c     = '0;
      win_any   = 1'b0;
      ptr_nxt   = '0;
    end
  end

  assign wr.gnt = gnt_c;

  // Steer the granted requester's address and pixel onto the write path.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_addr = wr.waddr[i*AW +: AW];
        win_data = wr.wdata[i*DW +: DW];
      end
    end
  end

  assign win_in_range = (win_addr < AW'(STRIP_WORDS));

  // Registered write port, bank select, drop counter and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
      bank_sel  <= 1'b0;
      err_cnt   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      vram_we <= win_any && win_in_range;
      if (win_any && win_in_range) begin
        vram_addr <= win_addr;
        vram_din  <= win_data;
      end
      if (win_any && !win_in_range && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (state == SWAP) begin
        bank_sel <= ~bank_sel;
      end
      busy <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomized scoreboard bench for vram_write_arbiter against a cycle-level reference model.
module tb_vram_write_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 19;
  localparam int unsigned DW   = 12;
  localparam int unsigned SW   = 20480;

  logic          clk;
  logic          reset;
  logic          window_open;
  logic          swap;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_din;
  logic          bank_sel;
  logic [7:0]    err_cnt;
  logic          busy;

  vram_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  vram_write_arbiter #(
    .NREQ        (NREQ),
    .AW          (AW),
    .DW          (DW),
    .STRIP_WORDS (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .window_open (window_open),
    .swap        (swap),
    .wr          (bus),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_din    (vram_din),
    .bank_sel    (bank_sel),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
    logic            bank;
    logic [7:0]      err;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [AW-1:0] a_arr [NREQ];
  logic [DW-1:0] d_arr [NREQ];

  // Reference model: "writes enabled" flag, boundary-cycle flag, rotation start and expected outputs.
  bit            m_run;
  bit            m_swapping;
  int            m_first;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  bit            m_bank;
  int            m_err;
  bit            m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_run      = 1'b0;
    m_swapping = 1'b0;
    m_first    = 0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_din      = '0;
    m_bank     = 1'b0;
    m_err      = 0;
    m_busy     = 1'b0;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] rr;
    rr = r;
`ifdef VRAM_ARB_PRIO_EN
    if (r[0]) return 0;
    rr[0] = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_first + k) % NREQ;
      if (rr[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.req     = '0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    window_open = 1'b0;
    swap        = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = AW'($urandom_range(0, SW - 1));
      d_arr[i] = DW'($urandom);
    end
  endtask

  // One clock cycle of stimulus; pushes what the DUT must show during this cycle.
  task automatic step(input logic [NREQ-1:0] r, input bit w, input bit s);
    exp_t e;
    int   win;
    @(posedge clk);
    #1;
    bus.req     = r;
    window_open = w;
    swap        = s;
    for (int i = 0; i < NREQ; i++) begin
      bus.waddr[i*AW +: AW] = a_arr[i];
      bus.wdata[i*DW +: DW] = d_arr[i];
    end
    win    = (m_run && w && !s) ? model_pick(r) : -1;
    e.gnt  = (win >= 0) ? (NREQ'(1) << win) : '0;
    e.we   = m_we;
    e.addr = m_addr;
    e.din  = m_din;
    e.bank = m_bank;
    e.err  = 8'(m_err);
    e.busy = m_busy;
    exp_q.push_back(e);

    m_we = 1'b0;
    if (win >= 0) begin
      if (a_arr[win] < AW'(SW)) begin
        m_we   = 1'b1;
        m_addr = a_arr[win];
        m_din  = d_arr[win];
      end else if (m_err < 255) begin
        m_err++;
      end
`ifdef VRAM_ARB_PRIO_EN
      if (win != 0) m_first = (win + 1) % NREQ;
`else
      m_first = (win + 1) % NREQ;
`endif
    end
    if (m_swapping) begin
      m_bank  = !m_bank;
      m_first = 0;
    end
    if (s) begin
      m_swapping = 1'b1;
      m_run      = 1'b0;
    end else begin
      m_swapping = 1'b0;
      m_run      = w;
    end
    m_busy = m_run;
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt",      32'(bus.gnt),   32'(e.gnt));
      check("vram_we",  32'(vram_we),   32'(e.we));
      check("vram_addr",32'(vram_addr), 32'(e.addr));
      check("vram_din", 32'(vram_din),  32'(e.din));
      check("bank_sel", 32'(bank_sel),  32'(e.bank));
      check("err_cnt",  32'(err_cnt),   32'(e.err));
      check("busy",     32'(busy),      32'(e.busy));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(bus.gnt),   32'd0);
    check({tag, "_we"},   32'(vram_we),   32'd0);
    check({tag, "_addr"}, 32'(vram_addr), 32'd0);
    check({tag, "_din"},  32'(vram_din),  32'd0);
    check({tag, "_bank"}, 32'(bank_sel),  32'd0);
    check({tag, "_err"},  32'(err_cnt),   32'd0);
    check({tag, "_busy"}, 32'(busy),      32'd0);
  endtask

  initial begin
    bit w;
    bit s;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    model_reset();
    #5;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fairness with every requester asking continuously.
    rand_data();
    step(4'b0000, 1'b1, 1'b0);
    repeat (10) begin
      rand_data();
      step(4'b1111, 1'b1, 1'b0);
    end

    // Window closes after three grants to requester 2.
    a_arr[2] = AW'(100);
    d_arr[2] = 12'hF00;
    repeat (3) step(4'b0100, 1'b1, 1'b0);
    repeat (3) step(4'b0100, 1'b0, 1'b0);

    // Two strip boundaries with a pending request.
    rand_data();
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b1);
    repeat (3) step(4'b0010, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b1);
    repeat (3) step(4'b1111, 1'b1, 1'b0);

    // Third boundary leaves bank B selected, then reset lands mid-RUN.
    step(4'b0000, 1'b1, 1'b1);
    repeat (4) begin
      rand_data();
      step(4'b1111, 1'b1, 1'b0);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("held_rst");
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic with occasional out-of-range addresses, window changes and swaps.
    w = 1'b1;
    repeat (1500) begin
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = ($urandom_range(0, 49) == 0) ? AW'(SW + $urandom_range(0, 100))
                                                 : AW'($urandom_range(0, SW - 1));
        d_arr[i] = DW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) w = !w;
      s = ($urandom_range(0, 39) == 0);
      step(NREQ'($urandom), w, s);
    end

    // Requester 3 hammers the first out-of-range address until the counter saturates.
    rand_data();
    a_arr[3] = AW'(SW);
    step(4'b0000, 1'b1, 1'b0);
    repeat (300) step(4'b1000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("err_saturated", 32'(err_cnt), 32'd255);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
